// File: rtl/lim_counter.sv
// Modulo-L up/down counter with synchronous clear/load, cascade carry and a
// sticky error flag for out-of-range loads.
module lim_counter #(
   parameter int N = 4,
   parameter int L = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ci,
   input  logic         up,
   input  logic         clr,
   input  logic         ld,
   input  logic [N-1:0] d,
   output logic [N-1:0] q,
   output logic         co,
   output logic         err
);

   typedef enum logic {IDLE, COUNT} mode_t;

   // Compared one bit wider so that L = 2^N is representable.
   localparam logic [N:0] LIM  = (N+1)'(L);
   localparam logic [N:0] LAST = (N+1)'(L - 1);

   mode_t        mode;
   logic [N-1:0] q_nxt;
   logic         err_nxt;
   logic         at_top;
   logic         at_bot;

   function automatic logic [N-1:0] step(input logic [N-1:0] cur, input logic dir);
      logic [N:0] c;
      c = {1'b0, cur};
      if (dir)
         return (c == LAST) ? '0 : N'(c + (N+1)'(1));
      else
         return (c == '0) ? N'(LAST) : N'(c - (N+1)'(1));
   endfunction

   assign at_top = ({1'b0, q} == LAST);
   assign at_bot = (q == '0);
   assign co     = ci & ~clr & ~ld & ((up & at_top) | (~up & at_bot));

   always_comb begin
      mode = IDLE;
      if (ci)
         mode = COUNT;
   end

   always_comb begin
      q_nxt   = q;
      err_nxt = err;
      if (clr) begin
         q_nxt   = '0;
         err_nxt = 1'b0;
      end else if (ld) begin
         if ({1'b0, d} >= LIM) begin
            q_nxt   = '0;
            err_nxt = 1'b1;
         end else begin
            q_nxt = d;
         end
      end else if (mode == COUNT) begin
         q_nxt = step(q, up);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= '0;
         err <= 1'b0;
      end else begin
         q   <= q_nxt;
         err <= err_nxt;
      end
   end

endmodule

// File: tb/tb_lim_counter.sv
// Directed bench for lim_counter: L=11 functional cases plus exhaustive
// next-state/carry sweeps of L=16 and L=2 instances.
module tb_lim_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, ci, up, clr, ld;
   logic [3:0] d, q;
   logic       co, err;

   logic       x_ci, x_up, x_clr, x_ld, x_co, x_err;
   logic [3:0] x_d, x_q;
   logic       y_ci, y_up, y_clr, y_ld, y_co, y_err;
   logic [3:0] y_d, y_q;

   int n_cmp = 0;
   int n_bad = 0;

   lim_counter #(.N(4), .L(11)) u_dut (
      .clk(clk), .rst_n(rst_n), .ci(ci), .up(up), .clr(clr), .ld(ld),
      .d(d), .q(q), .co(co), .err(err));

   lim_counter #(.N(4), .L(16)) u_l16 (
      .clk(clk), .rst_n(rst_n), .ci(x_ci), .up(x_up), .clr(x_clr), .ld(x_ld),
      .d(x_d), .q(x_q), .co(x_co), .err(x_err));

   lim_counter #(.N(4), .L(2)) u_l2 (
      .clk(clk), .rst_n(rst_n), .ci(y_ci), .up(y_up), .clr(y_clr), .ld(y_ld),
      .d(y_d), .q(y_q), .co(y_co), .err(y_err));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_next(input int cur, input int dir, input int en, input int lim);
      if (!en) return cur;
      if (dir) return (cur + 1) % lim;
      return (cur + lim - 1) % lim;
   endfunction

   function automatic int ref_co(input int cur, input int dir, input int en, input int lim);
      if (!en) return 0;
      if (dir) return (cur == lim - 1) ? 1 : 0;
      return (cur == 0) ? 1 : 0;
   endfunction

   initial begin
      int exp_q;
      int iters;
      int bad_before;

      rst_n = 1'b0; ci = 1'b0; up = 1'b0; clr = 1'b0; ld = 1'b0; d = '0;
      x_ci = 1'b0; x_up = 1'b0; x_clr = 1'b0; x_ld = 1'b0; x_d = '0;
      y_ci = 1'b0; y_up = 1'b0; y_clr = 1'b0; y_ld = 1'b0; y_d = '0;
      #12;
      chk("rst_q", q, 0);
      chk("rst_err", err, 0);
      ci = 1'b1; up = 1'b0; #1;
      chk("rst_co_down", co, 1);
      up = 1'b1; #1;
      chk("rst_co_up", co, 0);
      ci = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // count up through the wrap
      ci = 1'b1; up = 1'b1;
      exp_q = 0;
      for (int i = 1; i <= 12; i++) begin
         chk("up_co", co, (exp_q == 10) ? 1 : 0);
         tick();
         exp_q = i % 11;
         chk("up_q", q, exp_q);
      end
      ci = 1'b0; tick();
      chk("hold_q", q, 1);

      // count down from zero
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_q", q, 0);
      ci = 1'b1; up = 1'b0; #1;
      chk("dn_co0", co, 1);
      tick(); chk("dn_q10", q, 10); chk("dn_co10", co, 0);
      tick(); chk("dn_q9", q, 9);
      tick(); chk("dn_q8", q, 8);
      ci = 1'b0;

      // loads and sticky error
      ld = 1'b1; d = 4'd7; tick();
      chk("ld7_q", q, 7); chk("ld7_err", err, 0);
      d = 4'd13; tick();
      chk("ld13_q", q, 0); chk("ld13_err", err, 1);
      d = 4'd3; tick();
      chk("ld3_q", q, 3); chk("ld3_err", err, 1);
      ld = 1'b0; ci = 1'b1; up = 1'b1; tick();
      chk("cnt_q", q, 4); chk("cnt_err", err, 1);
      ci = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
      chk("clr2_q", q, 0); chk("clr2_err", err, 0);

      // priority
      ld = 1'b1; d = 4'd4; tick();
      clr = 1'b1; ld = 1'b1; ci = 1'b1; d = 4'd5; tick();
      chk("pri_clr_q", q, 0);
      clr = 1'b0; ci = 1'b0; d = 4'd10; tick();
      chk("pri_pre_q", q, 10);
      ci = 1'b1; up = 1'b1; d = 4'd5; #1;
      chk("pri_ld_co", co, 0);
      tick();
      chk("pri_ld_q", q, 5);
      ld = 1'b0; ci = 1'b0;

      // asynchronous reset mid-cycle
      ld = 1'b1; d = 4'd6; tick(); ld = 1'b0;
      chk("ar_pre_q", q, 6);
      #3 rst_n = 1'b0;
      #1 chk("ar_q", q, 0);
      #1 rst_n = 1'b1;
      ci = 1'b1; up = 1'b1; tick();
      chk("ar_resume_q", q, 1);
      ci = 1'b0;

      // exhaustive sweep, L=16 then L=2
      iters = 0;
      bad_before = n_bad;
      for (int qq = 0; qq < 16; qq++)
         for (int u = 0; u < 2; u++)
            for (int c = 0; c < 2; c++) begin
               x_ld = 1'b1; x_d = 4'(qq); x_ci = 1'b0; tick();
               x_ld = 1'b0; x_ci = c[0]; x_up = u[0]; #1;
               chk("x16_co", x_co, ref_co(qq, u, c, 16));
               tick();
               chk("x16_q", x_q, ref_next(qq, u, c, 16));
               iters++;
            end
      x_ci = 1'b0;
      for (int qq = 0; qq < 2; qq++)
         for (int u = 0; u < 2; u++)
            for (int c = 0; c < 2; c++) begin
               y_ld = 1'b1; y_d = 4'(qq); y_ci = 1'b0; tick();
               y_ld = 1'b0; y_ci = c[0]; y_up = u[0]; #1;
               chk("x2_co", y_co, ref_co(qq, u, c, 2));
               tick();
               chk("x2_q", y_q, ref_next(qq, u, c, 2));
               iters++;
            end
      y_ci = 1'b0;
      chk("exh_flag", ((n_bad == bad_before) && (iters == 72)) ? 1 : 0, 1);
      chk("exh_err", {x_err, y_err}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
